// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the step-counter width helper.
package seq_divider_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Counter holds 0..WIDTH without wrapping during an operation.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple adder chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit a - b built from full_adder cells: a + ~b + 1. Borrow is the
// inverted final carry.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_fa
    full_adder u_fa (
      .a    (a[g]),
      .b    (~b[g]),
      .cin  (w_c[g]),
      .sum  (diff[g]),
      .cout (w_c[g+1])
    );
  end

  assign borrow = ~w_c[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits straight to DONE with quotient all ones.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_d, r_q, r_r;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_t, w_diff, w_r_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_borrow, w_last, w_unused_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_t = {r_r, r_q[WIDTH-1]};

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (w_t),
    .b      ({1'b0, r_d}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  assign w_r_nxt = w_borrow ? w_t : w_diff;
  assign w_q_nxt = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  // Restored remainder is always < divisor, so the top bit is always zero.
  assign w_unused_msb = w_r_nxt[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_d   <= divisor;
              r_q   <= dividend;
              r_r   <= '0;
              r_cnt <= '0;
            end else begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_r   <= w_r_nxt[WIDTH-1:0];
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt[WIDTH-1:0];
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): vector table plus hand-written
// sequences for mid-run start, back-to-back start and mid-run reset.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_chk = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;   // edges from accept edge to the edge raising done
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Caller is just after a rising edge. Returns just after a rising edge.
  task automatic do_op(input vec_t v, input string tag);
    int k;
    bit seen;
    bit busy_ok;
    start    = 1'b1;
    dividend = v.dvd;
    divisor  = v.dvs;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    k = 0; seen = 0; busy_ok = 1;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) seen = 1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    chk({tag, " done_seen"}, int'(seen), 1);
    chk({tag, " latency"}, k, v.lat);
    chk({tag, " busy_during"}, int'(busy_ok), 1);
    chk({tag, " quotient"}, int'(quotient), int'(v.q));
    chk({tag, " remainder"}, int'(remainder), int'(v.r));
    chk({tag, " div_by_zero"}, int'(div_by_zero), int'(v.z));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_fall"}, int'(done), 0);
    chk({tag, " busy_fall"}, int'(busy), 0);
    chk({tag, " quotient_hold"}, int'(quotient), int'(v.q));
    @(posedge clk); #1;
  endtask

  initial begin
    int dc[3];
    int nd;
    int cyc;
    bit any_done;
    vec_t v;

    vecs.push_back('{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 4});
    vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4});
    vecs.push_back('{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 4});
    vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4});
    vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4});
    vecs.push_back('{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 0});
    vecs.push_back('{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 4});
    vecs.push_back('{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 0});
    vecs.push_back('{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 4});
    vecs.push_back('{4'd7,  4'd2,  4'd3,  4'd1, 1'b0, 4});

    // Reset with garbage on the inputs
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst quotient", int'(quotient), 0);
    chk("rst remainder", int'(remainder), 0);
    chk("rst div_by_zero", int'(div_by_zero), 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle busy", int'(busy), 0);
    chk("idle done", int'(done), 0);
    @(posedge clk); #1;

    foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d_%0d/%0d", i, vecs[i].dvd, vecs[i].dvs));

    // Start pulsed mid-run with 1/1 on the inputs must be ignored
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    @(posedge clk); #1;                 // E1
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(posedge clk); #1;                 // E2
    @(posedge clk); #1;                 // E3
    start = 1'b0;
    any_done = 0;
    for (int i = 0; i < 10 && !any_done; i++) begin
      @(negedge clk);
      if (done) any_done = 1;
      else @(posedge clk);
    end
    chk("midstart done_seen", int'(any_done), 1);
    chk("midstart quotient", int'(quotient), 3);
    chk("midstart remainder", int'(remainder), 1);
    any_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) any_done = 1;
    end
    chk("midstart no_extra_op", int'(any_done), 0);
    @(posedge clk); #1;

    // Start held high: back-to-back operations every W+2 cycles
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    nd = 0;
    for (cyc = 0; cyc < 40 && nd < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        dc[nd] = cyc;
        nd++;
        chk($sformatf("b2b quotient%0d", nd), int'(quotient), 3);
      end
    end
    start = 1'b0;
    chk("b2b done_count", nd, 3);
    if (nd == 3) begin
      chk("b2b period1", dc[1] - dc[0], W + 2);
      chk("b2b period2", dc[2] - dc[1], W + 2);
    end
    repeat (8) @(posedge clk);
    #1;

    // Reset pulsed mid-run: async clear, no done
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    @(posedge clk); #1;                 // E1
    @(posedge clk); #1;                 // E2
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst quotient", int'(quotient), 0);
    chk("midrst remainder", int'(remainder), 0);
    chk("midrst div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) any_done = 1;
    end
    chk("midrst no_done", int'(any_done), 0);
    @(posedge clk); #1;
    v = '{4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4};
    do_op(v, "after_rst_14/3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider, WIDTH bits, one quotient bit per clock. It undoes the arithmetic of the ripple-carry adder chain by repeated shift-and-subtract. It uses the existing `full_adder` cell in subtract mode (inverted subtrahend, carry-in 1). It sits beside the adder datapath and is driven by a start/done handshake from the surrounding control logic.

## Interface
- `WIDTH`, 4: operand, quotient and remainder width; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  unsigned numerator; sampled with `start`.
- `divisor`  in  WIDTH  unsigned denominator; sampled with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; results are valid in this cycle and afterwards.
- `quotient`  out  WIDTH  result; held until the next accepted start.
- `remainder`  out  WIDTH  result; held until the next accepted start.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held like the results.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1, divisor≠0 → RUN. Latch D=divisor, Q=dividend, R=0, step count=0.
  - IDLE, start=1, divisor=0 → DONE. Write quotient=all ones, remainder=dividend, div_by_zero=1.
  - RUN performs one step per cycle. The edge that completes step WIDTH-1 writes quotient=Q and remainder=R[WIDTH-1:0], clears div_by_zero, and moves to DONE.
  - DONE → IDLE unconditionally after one cycle.
- One step:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - Compute T − {0,D} in WIDTH+1 bits.
  - If no borrow: R=difference, Q={Q[WIDTH-2:0],1}.
  - If borrow: R=T, Q={Q[WIDTH-2:0],0}.
- Invariant at DONE: dividend = quotient·divisor + remainder, and remainder < divisor (divisor≠0).
- `start` in RUN or DONE is ignored; no queueing.
- Input operands are not observed after the accepting edge.
- Step counter is ⌈log2(WIDTH+1)⌉ bits and does not wrap within an operation.

## Timing
- Reset (async, any state): state=IDLE. busy, done, quotient, remainder, div_by_zero, R, Q, D and count all clear to 0.
- Start accepted at edge E0:
  - busy rises after E0.
  - Steps occur at edges E1..E_WIDTH.
  - done is high for the one cycle between E_WIDTH and E_WIDTH+1.
  - busy falls after E_WIDTH+1.
  - Latency from start to done is WIDTH+1 cycles; throughput is one operation per WIDTH+2 cycles.
- Divide-by-zero: done is high in the cycle after E0; busy is high in that cycle only.
- Earliest next accept is at the edge after DONE, with start held high through DONE.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced. The first start after deassertion behaves normally.
- `done` and `busy` are registered or decoded from state only, with no combinational path from inputs.

## Structure
- Package `seq_divider_pkg`:
  - State encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
  - Count-width function.
- Sub-module `ripple_subtractor` (parameter N=WIDTH+1):
  - Computes a − b as a chain of `full_adder` cells with b inverted and carry-in 1'b0→1'b1.
  - Outputs `diff[N-1:0]` and `borrow = ~carry_out`.
  - Purely combinational, instantiated once in the RUN datapath.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, idle 5 cycles → busy=0, done=0.
- 13/4, start at E0 → done only in cycle E4–E5, quotient=3, remainder=1, div_by_zero=0, busy high for cycles E0–E5.
- Boundaries: 15/1 → 15 r0. 3/7 → 0 r3. 0/5 → 0 r0. 15/15 → 1 r0. Each has latency 5 cycles.
- 9/0 → done in the cycle after E0, quotient=15, remainder=9, div_by_zero=1. A following 8/2 → 4 r0 with div_by_zero=0.
- Start pulsed at E2 of a 13/4 run with 1/1 on the inputs → ignored, result 3 r1. Start held high continuously → back-to-back ops every 6 cycles.
- rst_n pulsed low at E2 of a 14/3 run → outputs zero asynchronously, no done. A subsequent 14/3 → 4 r2.
